// File: rtl/pcc_drv_pkg.sv
// Shared constants, FSM state type and a saturating-increment helper for the
// pcc frame driver.
package pcc_drv_pkg;

    localparam int N_POS_DEF     = 6;
    localparam int N_NEG_DEF     = 9;
    localparam int CNT_W_DEF     = 16;
    localparam int FRAME_LEN_DEF = N_POS_DEF + N_NEG_DEF;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        DROP  = 2'd1,
        EVAL  = 2'd2,
        OUT   = 2'd3
    } pcc_state_e;

    // Increment v, holding at 2^w-1 (w up to 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/pcc_exact_ref.sv
// Exact reference decision: popcount(pos) >= popcount(neg). Only instantiated
// by pcc_frame_driver when EXACT_REF_EN is defined.
module pcc_exact_ref #(
    parameter int N_POS = 6,
    parameter int N_NEG = 9
) (
    input  logic [N_POS-1:0] pos_i,
    input  logic [N_NEG-1:0] neg_i,
    output logic             exact_o
);

    int pos_cnt;
    int neg_cnt;

    always_comb begin
        pos_cnt = 0;
        neg_cnt = 0;
        for (int i = 0; i < N_POS; i++) pos_cnt = pos_cnt + int'(pos_i[i]);
        for (int i = 0; i < N_NEG; i++) neg_cnt = neg_cnt + int'(neg_i[i]);
        exact_o = (pos_cnt >= neg_cnt);
    end

endmodule

// File: rtl/pcc_frame_driver.sv
// Serial-to-frame driver for the pcc classifier: assembles pos/neg bits, samples
// the classifier decision, returns it on valid/ready and keeps statistics.
// Optional macro EXACT_REF_EN adds an exact popcount reference and disagreement counter.
//
// Handshakes: a beat moves on s_valid && s_ready, a result moves on
// m_valid && m_ready; valid never depends on ready and data is held while valid.
module pcc_frame_driver
    import pcc_drv_pkg::*;
#(
    parameter int N_POS = N_POS_DEF,
    parameter int N_NEG = N_NEG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    input  logic             s_last,
    input  logic             s_label,
    output logic [N_POS-1:0] pcc_pos,
    output logic [N_NEG-1:0] pcc_neg,
    input  logic             pcc_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_class,
    output logic             m_correct,
    output logic             frame_err,
    output logic [CNT_W-1:0] n_samples,
    output logic [CNT_W-1:0] n_errors,
`ifdef EXACT_REF_EN
    output logic             m_exact,
    output logic [CNT_W-1:0] n_disagree,
`endif
    output pcc_state_e       dbg_state
);

    localparam int FRAME_LEN = N_POS + N_NEG;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    pcc_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d, frame_next;
    logic                 label_q, label_d;
    logic [N_POS-1:0]     pos_q, pos_d;
    logic [N_NEG-1:0]     neg_q, neg_d;
    logic                 class_q, class_d;
    logic                 correct_q, correct_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     samples_q, samples_d;
    logic [CNT_W-1:0]     errors_q, errors_d;
    logic                 accept;

    assign s_ready = (state_q == SHIFT) || (state_q == DROP);
    assign m_valid = (state_q == OUT);
    assign accept  = s_valid && s_ready;

    always_comb begin
        frame_next = frame_q;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (idx_q == IDX_W'(i)) frame_next[i] = s_bit;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        label_d   = label_q;
        pos_d     = pos_q;
        neg_d     = neg_q;
        class_d   = class_q;
        correct_d = correct_q;
        err_d     = 1'b0;
        samples_d = samples_q;
        errors_d  = errors_q;
        case (state_q)
            SHIFT: begin
                if (accept) begin
                    frame_d = frame_next;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            label_d = s_label;
                            pos_d   = frame_next[N_POS-1:0];
                            neg_d   = frame_next[FRAME_LEN-1:N_POS];
                            state_d = EVAL;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end else if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DROP: begin
                if (accept && s_last) state_d = SHIFT;
            end
            EVAL: begin
                // pcc_pos/pcc_neg were registered last cycle, so pcc_out has settled.
                class_d   = pcc_out;
                correct_d = (pcc_out == label_q);
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    samples_d = CNT_W'(sat_inc(32'(samples_q), CNT_W));
                    if (!correct_q) errors_d = CNT_W'(sat_inc(32'(errors_q), CNT_W));
                    state_d = SHIFT;
                end
            end
            default: state_d = SHIFT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SHIFT;
            idx_q     <= '0;
            frame_q   <= '0;
            label_q   <= 1'b0;
            pos_q     <= '0;
            neg_q     <= '0;
            class_q   <= 1'b0;
            correct_q <= 1'b0;
            err_q     <= 1'b0;
            samples_q <= '0;
            errors_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            label_q   <= label_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            class_q   <= class_d;
            correct_q <= correct_d;
            err_q     <= err_d;
            samples_q <= samples_d;
            errors_q  <= errors_d;
        end
    end

    assign pcc_pos   = pos_q;
    assign pcc_neg   = neg_q;
    assign m_class   = class_q;
    assign m_correct = correct_q;
    assign frame_err = err_q;
    assign n_samples = samples_q;
    assign n_errors  = errors_q;
    assign dbg_state = state_q;

`ifdef EXACT_REF_EN
    logic             exact_w;
    logic             exact_q, exact_d;
    logic [CNT_W-1:0] disagree_q, disagree_d;

    pcc_exact_ref #(.N_POS(N_POS), .N_NEG(N_NEG)) u_exact_ref (
        .pos_i   (pos_q),
        .neg_i   (neg_q),
        .exact_o (exact_w)
    );

    always_comb begin
        exact_d    = exact_q;
        disagree_d = disagree_q;
        if (state_q == EVAL) exact_d = exact_w;
        if (state_q == OUT && m_ready && (exact_q != class_q))
            disagree_d = CNT_W'(sat_inc(32'(disagree_q), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exact_q    <= 1'b0;
            disagree_q <= '0;
        end else begin
            exact_q    <= exact_d;
            disagree_q <= disagree_d;
        end
    end

    assign m_exact    = exact_q;
    assign n_disagree = disagree_q;
`endif

endmodule

// File: tb/tb_pcc_frame_driver.sv
// Randomized self-checking bench for pcc_frame_driver (main instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation).
module tb_pcc_frame_driver;
  import pcc_drv_pkg::*;

  localparam int N_POS = 6;
  localparam int N_NEG = 9;
  localparam int CNT_W = 16;
  localparam int FRAME_LEN = N_POS + N_NEG;
  localparam int MAX1 = (1 << CNT_W) - 1;
  localparam int MAX2 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_valid = 1'b0, s_bit = 1'b0, s_last = 1'b0, s_label = 1'b0, m_ready = 1'b0;
  int   pcc_mode = 0;

  logic s_ready, pcc_out, m_valid, m_class, m_correct, frame_err;
  logic [N_POS-1:0] pcc_pos;
  logic [N_NEG-1:0] pcc_neg;
  logic [CNT_W-1:0] n_samples, n_errors;
  pcc_state_e dbg_state;

  logic s_ready2, pcc_out2, m_valid2, m_class2, m_correct2, frame_err2;
  logic [N_POS-1:0] pcc_pos2;
  logic [N_NEG-1:0] pcc_neg2;
  logic [1:0] n_samples2, n_errors2;
  pcc_state_e dbg_state2;
`ifdef EXACT_REF_EN
  logic m_exact, m_exact2;
  logic [CNT_W-1:0] n_disagree;
  logic [1:0] n_disagree2;
`endif

  // External classifier model driven from the registered vectors.
  function automatic logic classify(input logic [N_POS-1:0] p, input logic [N_NEG-1:0] n, input int mode);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      default: return ($countones(p) + 2 >= $countones(n));
    endcase
  endfunction

  assign pcc_out  = classify(pcc_pos, pcc_neg, pcc_mode);
  assign pcc_out2 = classify(pcc_pos2, pcc_neg2, pcc_mode);

  pcc_frame_driver #(.N_POS(N_POS), .N_NEG(N_NEG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit),
    .s_last(s_last), .s_label(s_label), .pcc_pos(pcc_pos), .pcc_neg(pcc_neg),
    .pcc_out(pcc_out), .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .m_correct(m_correct), .frame_err(frame_err), .n_samples(n_samples),
    .n_errors(n_errors),
`ifdef EXACT_REF_EN
    .m_exact(m_exact), .n_disagree(n_disagree),
`endif
    .dbg_state(dbg_state)
  );

  pcc_frame_driver #(.N_POS(N_POS), .N_NEG(N_NEG), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_bit(s_bit),
    .s_last(s_last), .s_label(s_label), .pcc_pos(pcc_pos2), .pcc_neg(pcc_neg2),
    .pcc_out(pcc_out2), .m_valid(m_valid2), .m_ready(m_ready), .m_class(m_class2),
    .m_correct(m_correct2), .frame_err(frame_err2), .n_samples(n_samples2),
    .n_errors(n_errors2),
`ifdef EXACT_REF_EN
    .m_exact(m_exact2), .n_disagree(n_disagree2),
`endif
    .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];           // {exact, class, correct}
  logic [N_POS-1:0] exp_pos;
  logic [N_NEG-1:0] exp_neg;
  int exp_samples = 0, exp_errors = 0, exp_disagree = 0;
  int err_pulses = 0;

  always @(posedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_counters(input string tag);
    check_eq({tag, "_n_samples"}, 32'(n_samples), 32'(clip(exp_samples, MAX1)));
    check_eq({tag, "_n_errors"}, 32'(n_errors), 32'(clip(exp_errors, MAX1)));
    check_eq({tag, "_n_samples_w2"}, 32'(n_samples2), 32'(clip(exp_samples, MAX2)));
    check_eq({tag, "_n_errors_w2"}, 32'(n_errors2), 32'(clip(exp_errors, MAX2)));
`ifdef EXACT_REF_EN
    check_eq({tag, "_n_disagree"}, 32'(n_disagree), 32'(clip(exp_disagree, MAX1)));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_stream(input logic [31:0] bits, input int len, input logic label, input bit use_last);
    for (int i = 0; i < len; i++) begin
      int guard;
      @(negedge clk);
      s_valid = 1'b1;
      s_bit   = bits[i];
      s_last  = use_last && (i == len - 1);
      s_label = (i == len - 1) ? label : ~label;
      guard = 0;
      while (!s_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check_eq("s_ready_timeout", 32'(s_ready), 32'd1);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    exp_samples = 0;
    exp_errors = 0;
    exp_disagree = 0;
    exp_pos = '0;
    exp_neg = '0;
    exp_q.delete();
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_class", 32'(m_class), 32'd0);
    check_eq("rst_m_correct", 32'(m_correct), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_pcc_pos", 32'(pcc_pos), 32'd0);
    check_eq("rst_pcc_neg", 32'(pcc_neg), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(SHIFT));
`ifdef EXACT_REF_EN
    check_eq("rst_m_exact", 32'(m_exact), 32'd0);
`endif
    check_counters("rst");
    rst = 1'b0;
  endtask

  task automatic good_frame(input logic [14:0] bits, input logic label, input int hold);
    logic [N_POS-1:0] p;
    logic [N_NEG-1:0] n;
    logic cls, ex;
    logic [2:0] e;
    int cycles, pulses0;
    p = bits[N_POS-1:0];
    n = bits[FRAME_LEN-1:N_POS];
    cls = classify(p, n, pcc_mode);
    ex = ($countones(p) >= $countones(n));
    exp_q.push_back({ex, cls, cls == label});
    pulses0 = err_pulses;
    send_stream(32'(bits), FRAME_LEN, label, 1'b1);
    exp_pos = p;
    exp_neg = n;
    cycles = 1;
    while (!m_valid && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("latency", 32'(cycles), 32'd2);
    e = exp_q.pop_front();
    check_eq("m_class", 32'(m_class), 32'(e[1]));
    check_eq("m_correct", 32'(m_correct), 32'(e[0]));
`ifdef EXACT_REF_EN
    check_eq("m_exact", 32'(m_exact), 32'(e[2]));
`endif
    check_eq("pcc_pos", 32'(pcc_pos), 32'(exp_pos));
    check_eq("pcc_neg", 32'(pcc_neg), 32'(exp_neg));
    check_eq("out_s_ready", 32'(s_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_eq("hold_m_valid", 32'(m_valid), 32'd1);
      check_eq("hold_s_ready", 32'(s_ready), 32'd0);
      check_eq("hold_m_class", 32'(m_class), 32'(e[1]));
      check_counters("hold");
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_samples = sat(exp_samples, 1 << 30);
    if (!e[0]) exp_errors = sat(exp_errors, 1 << 30);
    if (e[2] != e[1]) exp_disagree = sat(exp_disagree, 1 << 30);
    check_eq("post_m_valid", 32'(m_valid), 32'd0);
    check_eq("post_s_ready", 32'(s_ready), 32'd1);
    check_eq("good_err_pulses", 32'(err_pulses - pulses0), 32'd0);
    check_counters("post");
    @(negedge clk);
    check_counters("once");
  endtask

  task automatic bad_frame(input logic [31:0] bits, input int len);
    int pulses0;
    pulses0 = err_pulses;
    send_stream(bits, len, 1'($urandom_range(0, 1)), 1'b1);
    repeat (2) @(negedge clk);
    check_eq("bad_err_pulses", 32'(err_pulses - pulses0), 32'd1);
    check_eq("bad_m_valid", 32'(m_valid), 32'd0);
    check_eq("bad_pcc_pos_held", 32'(pcc_pos), 32'(exp_pos));
    check_counters("bad");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();

    pcc_mode = 0;
    good_frame(15'h7FFF, 1'b1, 0);

    pcc_mode = 1;
    good_frame({9'h1FF, 6'h00}, 1'b1, 0);

    pcc_mode = 2;
    bad_frame($urandom, 10);
    good_frame(15'($urandom), 1'($urandom_range(0, 1)), 0);

    bad_frame($urandom, 20);
    good_frame(15'($urandom), 1'($urandom_range(0, 1)), 0);

    good_frame(15'($urandom), 1'($urandom_range(0, 1)), 10);

    send_stream($urandom, 7, 1'b0, 1'b0);
    do_reset();
    good_frame(15'($urandom), 1'($urandom_range(0, 1)), 0);

    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      pcc_mode = $urandom_range(0, 2);
      if (r == 0) bad_frame($urandom, $urandom_range(1, 14));
      else if (r == 1) bad_frame($urandom, $urandom_range(16, 25));
      else good_frame(15'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check_eq("w2_saturated", 32'(n_samples2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
